// File: rtl/arm_test_pkg.sv
// Shared definitions for the test status responder: register offsets, FSM states, status bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_test_pkg;

  // Byte offsets of the window registers relative to BASE
  localparam logic [31:0] OFF_RESULT   = 32'd0;
  localparam logic [31:0] OFF_CYCLES   = 32'd4;
  localparam logic [31:0] OFF_WRITES   = 32'd8;
  localparam logic [31:0] OFF_LAST_ADR = 32'd12;
  localparam logic [31:0] WIN_BYTES    = 32'd16;

  // Responder state; every state except ST_RUN is terminal until reset
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  // Bit positions inside the RESULT status word
  localparam int STAT_PASS    = 0;
  localparam int STAT_FAIL    = 1;
  localparam int STAT_TIMEOUT = 2;

  // Pack the three terminal flags into the RESULT read word
  function automatic logic [31:0] status_word(input logic p, input logic f, input logic t);
    logic [31:0] w;
    w               = '0;
    w[STAT_PASS]    = p;
    w[STAT_FAIL]    = f;
    w[STAT_TIMEOUT] = t;
    return w;
  endfunction

endpackage

// File: rtl/test_status_responder_if.sv
// Data-memory bus as seen by the test status responder (processor side is master).
// Latency: ReadData/hit are combinational from Adr.
// Backpressure: none; the responder accepts every store immediately.
interface test_status_responder_if;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        hit;

  modport master (output Adr, output WriteData, output MemWrite,
                  input  ReadData, input hit);
  modport slave  (input  Adr, input WriteData, input MemWrite,
                  output ReadData, output hit);
endinterface

// File: rtl/test_status_responder_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Latency: q updates on the clock edge where en is sampled high.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count up while enabled, stick at all-ones so a long run never reads back small
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/test_status_responder.sv
// Memory-mapped self-test reporter: latches pass/fail from RESULT writes, runs a watchdog, counts cycles/stores.
// Latency: status outputs 1 cycle after the triggering store/edge; ReadData/hit combinational.
// Backpressure: none; every MemWrite cycle is taken and counted.
module test_status_responder
  import arm_test_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'd100,
  parameter logic [31:0] PASS_CODE = 32'd8,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int          CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  test_status_responder_if.slave       bus,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [31:0]                  fail_value
);

  // Watchdog fires when CYCLES holds TIMEOUT-1 at an edge; a zero TIMEOUT disables it
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e            r_state;
  logic [31:0]       r_last_adr;
  logic [CNT_W-1:0]  w_cycles;
  logic [CNT_W-1:0]  w_writes;
  logic [31:0]       w_cycles32;
  logic [31:0]       w_writes32;
  logic [31:0]       w_off;
  logic              w_in_win;
  logic              w_hit;
  logic              w_run;
  logic              w_result_wr;
  logic              w_wd_fire;
  logic [31:0]       w_rdata;

  // Full 32-bit decode; BASE is word-aligned and the window never wraps past 2^32
  assign w_off       = bus.Adr - BASE;
  assign w_in_win    = (bus.Adr >= BASE) && (w_off < WIN_BYTES);
  assign w_hit       = w_in_win && (bus.Adr[1:0] == 2'b00);
  assign w_run       = (r_state == ST_RUN);
  assign w_result_wr = bus.MemWrite && w_hit && (w_off == OFF_RESULT);
  assign w_wd_fire   = WD_EN && (w_cycles32 == WD_LAST);

  // Counters only advance in RUN; terminal states freeze them for post-mortem reads
  sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (w_run),
    .q     (w_cycles)
  );

  sat_counter #(.W(CNT_W)) u_writes (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (w_run && bus.MemWrite),
    .q     (w_writes)
  );

  // Zero-extend the counters to the 32-bit read width
  always_comb begin
    w_cycles32              = '0;
    w_writes32              = '0;
    w_cycles32[CNT_W-1:0]   = w_cycles;
    w_writes32[CNT_W-1:0]   = w_writes;
  end

  // Result FSM with status flags registered alongside the state (1-cycle latency);
  // a RESULT store in the watchdog's firing cycle takes priority over TIMEOUT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_value <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_result_wr) begin
            done <= 1'b1;
            if (bus.WriteData == PASS_CODE) begin
              r_state <= ST_PASS;
              pass    <= 1'b1;
            end else begin
              r_state    <= ST_FAIL;
              fail       <= 1'b1;
              fail_value <= bus.WriteData;
            end
          end else if (w_wd_fire) begin
            r_state <= ST_TIMEOUT;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Remember the address of the most recent store anywhere on the bus while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_adr <= '0;
    end else if (w_run && bus.MemWrite) begin
      r_last_adr <= bus.Adr;
    end
  end

  // Read mux: purely from Adr and current register values, so a read during a store sees pre-store data
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off[3:0])
        OFF_RESULT[3:0]:   w_rdata = status_word(pass, fail, timeout);
        OFF_CYCLES[3:0]:   w_rdata = w_cycles32;
        OFF_WRITES[3:0]:   w_rdata = w_writes32;
        OFF_LAST_ADR[3:0]: w_rdata = r_last_adr;
        default:           w_rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = w_rdata;
  assign bus.hit      = w_hit;

endmodule

// File: doc/test_status_responder.md
Name: test_status_responder

Overview:
- Memory-mapped responder on the multicycle ARM data-memory interface (Adr, WriteData, MemWrite) that lets programs report their own result in hardware.
- Decodes a small register window, latches pass/fail and runs a watchdog.
- Exposes cycle and write counters as readable registers.
- Sits beside the data memory in top; benches and FPGA builds watch its status outputs instead of snooping the bus themselves.

Parameters:
- BASE, 100, byte address of the first window register; must be word-aligned.
- PASS_CODE, 8, value that declares success when written to RESULT.
- TIMEOUT, 1000, cycles after reset release before the watchdog fires; 0 disables it.
- CNT_W, 32, counter width, 1..32; read values are zero-extended to 32 bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Adr  in  32  processor byte address.
- WriteData  in  32  processor store data.
- MemWrite  in  1  store strobe, sampled each rising clk edge.
- ReadData  out  32  combinational read of the addressed window register; 0 when not hit.
- hit  out  1  combinational; Adr is inside the window and Adr[1:0]==0.
- done  out  1  registered; any terminal state reached.
- pass  out  1  registered; state is PASS.
- fail  out  1  registered; state is FAIL.
- timeout  out  1  registered; state is TIMEOUT.
- fail_value  out  32  registered; data written that caused FAIL.

Behaviour:
- Window, word offsets from BASE:
  - +0 RESULT, R/W.
  - +4 CYCLES, RO.
  - +8 WRITES, RO.
  - +12 LAST_ADR, RO.
- Reading RESULT returns a status word: {29'b0, timeout, fail, pass}.
- Reset (reset==0, asynchronous):
  - state=RUN.
  - CYCLES, WRITES, LAST_ADR, fail_value = 0.
  - done, pass, fail, timeout = 0.
- A write is any rising edge with MemWrite==1. Each such cycle counts once; if MemWrite is held for N cycles, that is N writes.
- State machine (RUN, PASS, FAIL, TIMEOUT):
  - RUN -> PASS: write to RESULT with WriteData==PASS_CODE.
  - RUN -> FAIL: write to RESULT with any other value; fail_value <= WriteData in the same edge.
  - RUN -> TIMEOUT: TIMEOUT!=0 and CYCLES reaches TIMEOUT-1 at the edge, with no RESULT write in that cycle.
  - PASS, FAIL and TIMEOUT are sticky until reset. Later RESULT writes are ignored and do not change fail_value.
- Status outputs are registered decodes of the state and go high on the edge after the triggering write, i.e. 1-cycle latency.
- In RUN, each edge:
  - CYCLES increments, saturating at all-ones of CNT_W.
  - On a write: WRITES increments (saturating) and LAST_ADR <= Adr. This covers every write, inside or outside the window.
- In terminal states, all counters and LAST_ADR freeze; reads still work.
- Simultaneous events: a RESULT write in the same cycle the watchdog would fire wins, giving PASS/FAIL, not TIMEOUT.
- Writes to RO offsets change no register but are still counted.
- Misaligned in-window addresses (Adr[1:0]!=0) are not hits: ReadData=0 and no RESULT effect, but they are counted.
- Address decode uses full 32-bit compare. There is no wrap-around at 2^32; a window crossing 2^32 is illegal (BASE <= 2^32-16).
- Reset asserted mid-operation: immediate return to reset values regardless of state. The first CYCLES increment is on the first edge with reset==1.
- Read path is purely combinational from Adr. ReadData never depends on MemWrite in the same cycle; a read during a write returns pre-write values.

Decomposition:
- Package arm_test_pkg holds:
  - Register offsets (OFF_RESULT=0, OFF_CYCLES=4, OFF_WRITES=8, OFF_LAST_ADR=12).
  - State enum RUN/PASS/FAIL/TIMEOUT.
  - Status bit positions.
- Sub-module sat_counter (parameter W; inputs clk, reset, clr, en; output q, saturating). Instantiate it twice, for CYCLES and WRITES.
- Decode, state machine and read mux stay in the top block.

Test Plan:
- Reset 3 cycles, release, 5 idle cycles, then a single-cycle write Adr=100 WriteData=8 -> pass=1 on the next edge; done=1; read Adr=100 returns 0x1. CYCLES stays frozen for the following 10 cycles.
- Write Adr=100 WriteData=7 -> fail=1, fail_value=7. A subsequent write of 8 to Adr=100 leaves fail=1, pass=0, fail_value=7.
- TIMEOUT=20 with no writes -> timeout=1 after exactly 20 edges post-release. A RESULT write=8 landing on edge 20 instead yields pass=1, timeout=0.
- Writes to 0x0, 0x68 (104, RO) and 0x65 (misaligned) -> WRITES=3, LAST_ADR=0x65; state RUN; reading 0x65 gives hit=0, ReadData=0.
- CNT_W=4 with 20 writes -> WRITES saturates at 15; CYCLES saturates at 15.
- Assert reset for half a cycle while in PASS -> all outputs drop to 0 asynchronously. After release, a write of 8 to Adr=100 passes again.
